// File: rtl/norm_shift_stage_if.sv
// -----------------------------------------------------------------------------
// norm_shift_stage_if
//   Bundles the upstream (LZC side) and downstream (rounding side) handshake
//   and data signals of the normalization stage.
//
//   Handshake rule on both sides: a transfer happens on a rising clock edge
//   where valid and ready are both 1. Once valid is raised, the producer
//   holds valid and data steady until that transfer. The consumer may
//   change ready at any time.
//
//   Signal summary
//     in_valid_i / in_ready_o  : upstream handshake
//     mant_i, exp_i            : unnormalized mantissa, signed biased exponent
//     lzc_cnt_i, lzc_empty_i   : leading-zero count / all-zero flag of mant_i
//     out_valid_o / out_ready_i: downstream handshake
//     mant_o, exp_o            : normalized mantissa, adjusted exponent
//     zero_o, denorm_o         : result flags
//
//   Modports
//     master : the side that drives the stage (producer + consumer stubs)
//     slave  : the normalization stage itself
// -----------------------------------------------------------------------------
interface norm_shift_stage_if #(
  parameter int MANT_WIDTH = 24,
  parameter int EXP_WIDTH  = 10,
  parameter int CNT_WIDTH  = (MANT_WIDTH > 1) ? $clog2(MANT_WIDTH) : 1
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [MANT_WIDTH-1:0] mant_i;
  logic [EXP_WIDTH-1:0]  exp_i;
  logic [CNT_WIDTH-1:0]  lzc_cnt_i;
  logic                  lzc_empty_i;

  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [MANT_WIDTH-1:0] mant_o;
  logic [EXP_WIDTH-1:0]  exp_o;
  logic                  zero_o;
  logic                  denorm_o;

  modport master (
    output in_valid_i, mant_i, exp_i, lzc_cnt_i, lzc_empty_i, out_ready_i,
    input  in_ready_o, out_valid_o, mant_o, exp_o, zero_o, denorm_o
  );

  modport slave (
    input  in_valid_i, mant_i, exp_i, lzc_cnt_i, lzc_empty_i, out_ready_i,
    output in_ready_o, out_valid_o, mant_o, exp_o, zero_o, denorm_o
  );
endinterface

// File: rtl/norm_shift_stage.sv
// -----------------------------------------------------------------------------
// norm_shift_stage
//   Two-stage elastic mantissa normalizer. Stage A decodes the shift amount,
//   result exponent and zero/denorm flags from the LZC result; stage B applies
//   the left shift. The exponent is never driven below 0: when the full
//   leading-zero shift would underflow, the shift is limited so that the
//   result lands on the subnormal exponent 0.
//
//   Ports
//     clk_i   : clock, rising edge
//     rst_i   : synchronous active-high reset
//     flush_i : synchronous kill of both in-flight entries
//     bus     : norm_shift_stage_if.slave (handshakes and data)
//
//   Latency 2 cycles, throughput 1/cycle, no skid buffer: in_ready_o is a
//   combinational function of the downstream ready.
// -----------------------------------------------------------------------------
module norm_shift_stage #(
  parameter  int MANT_WIDTH = 24,
  parameter  int EXP_WIDTH  = 10,
  localparam int CNT_WIDTH  = (MANT_WIDTH > 1) ? $clog2(MANT_WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  norm_shift_stage_if.slave    bus
);

  localparam int XW = EXP_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // Stage A decode (combinational on the input bus)
  // ---------------------------------------------------------------------------
  logic signed [XW-1:0]  w_exp_x;
  logic signed [XW-1:0]  w_cnt_x;
  logic signed [XW-1:0]  w_diff;
  logic                  w_diff_pos;
  logic                  w_exp_pos;
  logic [CNT_WIDTH-1:0]  w_exp_m1;

  logic [MANT_WIDTH-1:0] w_mant;
  logic [CNT_WIDTH-1:0]  w_shift;
  logic [EXP_WIDTH-1:0]  w_exp_res;
  logic                  w_zero;
  logic                  w_denorm;

  assign w_exp_x    = {bus.exp_i[EXP_WIDTH-1], bus.exp_i};
  assign w_cnt_x    = XW'(bus.lzc_cnt_i);
  assign w_diff     = w_exp_x - w_cnt_x;
  // ">= 1" written as "non-negative and non-zero" to stay width-exact.
  assign w_diff_pos = !w_diff[XW-1] && (w_diff != '0);
  assign w_exp_pos  = !w_exp_x[XW-1] && (w_exp_x != '0);
  // Only used when 1 <= exp_i <= cnt, so exp_i-1 < MANT_WIDTH fits CNT_WIDTH.
  assign w_exp_m1   = bus.exp_i[CNT_WIDTH-1:0] - CNT_WIDTH'(1);

  always_comb begin
    w_mant    = bus.mant_i;
    w_shift   = '0;
    w_exp_res = '0;
    w_zero    = 1'b0;
    w_denorm  = 1'b0;
    if (bus.lzc_empty_i) begin
      w_mant = '0;
      w_zero = 1'b1;
    end else if (w_diff_pos) begin
      w_shift   = bus.lzc_cnt_i;
      w_exp_res = w_diff[EXP_WIDTH-1:0];
    end else if (w_exp_pos) begin
      // Shift only far enough to bring the exponent down to the subnormal 0.
      w_shift  = w_exp_m1;
      w_denorm = 1'b1;
    end else begin
      w_denorm = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Elastic control
  // ---------------------------------------------------------------------------
  logic r_a_valid;
  logic r_b_valid;
  logic w_b_load;
  logic w_a_open;

  assign w_b_load       = !r_b_valid || bus.out_ready_i;
  // A can take a new entry when empty or when its current entry moves to B.
  assign w_a_open       = !r_a_valid || w_b_load;
  assign bus.in_ready_o = w_a_open && !rst_i;

  // ---------------------------------------------------------------------------
  // Stage A registers
  // ---------------------------------------------------------------------------
  logic [MANT_WIDTH-1:0] r_a_mant;
  logic [CNT_WIDTH-1:0]  r_a_shift;
  logic [EXP_WIDTH-1:0]  r_a_exp;
  logic                  r_a_zero;
  logic                  r_a_denorm;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_valid  <= 1'b0;
      r_a_mant   <= '0;
      r_a_shift  <= '0;
      r_a_exp    <= '0;
      r_a_zero   <= 1'b0;
      r_a_denorm <= 1'b0;
    end else if (flush_i) begin
      r_a_valid <= 1'b0;
    end else if (w_a_open) begin
      r_a_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        r_a_mant   <= w_mant;
        r_a_shift  <= w_shift;
        r_a_exp    <= w_exp_res;
        r_a_zero   <= w_zero;
        r_a_denorm <= w_denorm;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B registers (shift applied on load)
  // ---------------------------------------------------------------------------
  logic [MANT_WIDTH-1:0] r_b_mant;
  logic [EXP_WIDTH-1:0]  r_b_exp;
  logic                  r_b_zero;
  logic                  r_b_denorm;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_b_valid  <= 1'b0;
      r_b_mant   <= '0;
      r_b_exp    <= '0;
      r_b_zero   <= 1'b0;
      r_b_denorm <= 1'b0;
    end else if (flush_i) begin
      r_b_valid <= 1'b0;
    end else if (w_b_load) begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        r_b_mant   <= r_a_mant << r_a_shift;
        r_b_exp    <= r_a_exp;
        r_b_zero   <= r_a_zero;
        r_b_denorm <= r_a_denorm;
      end
    end
  end

  assign bus.out_valid_o = r_b_valid;
  assign bus.mant_o      = r_b_mant;
  assign bus.exp_o       = r_b_exp;
  assign bus.zero_o      = r_b_zero;
  assign bus.denorm_o    = r_b_denorm;

endmodule
